// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// A grant ends on done, a dropped request, or the hold limit, followed by a one-cycle gap.
module rr_arbiter_8 #(
   parameter int MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       timeout
);

   localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t     state_q;
   logic [2:0] ptr_q;
   logic [7:0] hold_cnt_q;
   logic [7:0] grant_q;
   logic [2:0] grant_idx_q;
   logic       grant_valid_q;
   logic       timeout_q;

   logic       found_d;
   logic [2:0] pick_d;
   logic [2:0] cand_d;
   logic       hold_hit_d;
   logic       req_own_d;
   logic       exit_d;
   logic       timeout_d;

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      onehot8 = 8'd1 << idx;
   endfunction

   // First set request at or after ptr_q, wrapping modulo 8
   always_comb begin
      found_d = 1'b0;
      pick_d  = 3'd0;
      cand_d  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         cand_d  = ptr_q + 3'(i);
         pick_d  = (!found_d && req[cand_d]) ? cand_d : pick_d;
         found_d = found_d | req[cand_d];
      end
   end

   assign hold_hit_d = (hold_cnt_q == MAX_HOLD_C);
   assign req_own_d  = req[grant_idx_q];
   assign exit_d     = done | ~req_own_d | hold_hit_d;
   // Only a pure hold-limit exit counts as a forced revocation
   assign timeout_d  = hold_hit_d & ~done & req_own_d;

   // Arbitration state machine with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         ptr_q         <= 3'd0;
         hold_cnt_q    <= 8'd0;
         grant_q       <= 8'd0;
         grant_idx_q   <= 3'd0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  state_q       <= GRANT;
                  grant_idx_q   <= pick_d;
                  grant_q       <= onehot8(pick_d);
                  grant_valid_q <= 1'b1;
                  hold_cnt_q    <= 8'd1;
               end else begin
                  state_q       <= IDLE;
               end
            end
            GRANT: begin
               if (exit_d) begin
                  state_q       <= GAP;
                  ptr_q         <= grant_idx_q + 3'd1;
                  grant_q       <= 8'd0;
                  grant_idx_q   <= 3'd0;
                  grant_valid_q <= 1'b0;
                  timeout_q     <= timeout_d;
               end else if (!hold_hit_d) begin
                  hold_cnt_q    <= hold_cnt_q + 8'd1;
               end else begin
                  hold_cnt_q    <= hold_cnt_q;
               end
            end
            GAP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q       <= IDLE;
               grant_q       <= 8'd0;
               grant_idx_q   <= 3'd0;
               grant_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_idx   = grant_idx_q;
   assign grant_valid = grant_valid_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8 (MAX_HOLD=4): stimulus queues expected grant
// episodes {idx, length, timeout}; a negedge monitor checks each episode as it ends.
module tb_rr_arbiter_8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0] idx;
      int         len;
      logic       to;
   } exp_t;

   exp_t exp_q[$];

   rr_arbiter_8 #(.MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic push(input logic [2:0] idx, input int len, input logic to);
      exp_t e;
      e.idx = idx;
      e.len = len;
      e.to  = to;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant();
      int n;
      n = 0;
      while (!grant_valid && n < 20) begin
         tick();
         n++;
      end
      chk("grant_arrived", 32'(grant_valid), 32'd1);
   endtask

   // Called in grant cycle 1; raises done in grant cycle n, returns in the gap cycle
   task automatic grant_with_done(input int n);
      repeat (n - 1) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   // Monitor: tracks each grant episode and compares it when the grant falls
   initial begin
      logic       prev_v;
      logic       active;
      logic       chg;
      int         len;
      logic [7:0] gcap;
      logic [2:0] icap;
      exp_t       e;
      prev_v = 1'b0;
      active = 1'b0;
      chg    = 1'b0;
      len    = 0;
      gcap   = 8'd0;
      icap   = 3'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            active = 1'b0;
            prev_v = 1'b0;
         end else begin
            if (grant_valid && !prev_v) begin
               active = 1'b1;
               len    = 1;
               gcap   = grant;
               icap   = grant_idx;
               chg    = 1'b0;
            end else if (grant_valid && active) begin
               len++;
               if (grant !== gcap || grant_idx !== icap) chg = 1'b1;
            end else if (!grant_valid && prev_v && active) begin
               active = 1'b0;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_grant: got idx %0d with no expectation", icap);
               end else begin
                  e = exp_q.pop_front();
                  chk("grant_idx", 32'(icap), 32'(e.idx));
                  chk("grant_onehot", 32'(gcap), 32'(8'd1 << e.idx));
                  chk("grant_len", 32'(len), 32'(e.len));
                  chk("timeout", 32'(timeout), 32'(e.to));
                  chk("grant_stable", 32'(chg), 32'd0);
                  chk("gap_grant_zero", 32'(grant), 32'd0);
               end
            end
            prev_v = grant_valid;
         end
      end
   end

   initial begin
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      #2;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_valid", 32'(grant_valid), 32'd0);
      chk("rst_idx", 32'(grant_idx), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // done while idle is ignored
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("idle_done_ignored", 32'(grant_valid), 32'd0);

      // single requester, done on 3rd grant cycle, then re-grant after gap+idle
      push(3'd2, 3, 1'b0);
      req = 8'h04;
      wait_grant();
      grant_with_done(3);
      chk("gap_valid", 32'(grant_valid), 32'd0);
      push(3'd2, 1, 1'b0);
      wait_grant();
      grant_with_done(1);
      req = 8'h00;
      tick();
      tick();

      // round-robin from reset pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         push(3'(k % 8), 1, 1'b0);
         wait_grant();
         grant_with_done(1);
      end

      // wrap: serve 6, then 8'h81 gives 7 then 0
      req = 8'h40;
      push(3'd6, 1, 1'b0);
      wait_grant();
      grant_with_done(1);
      req = 8'h81;
      push(3'd7, 1, 1'b0);
      wait_grant();
      grant_with_done(1);
      push(3'd0, 1, 1'b0);
      wait_grant();
      grant_with_done(1);
      req = 8'h00;
      tick();
      tick();

      // hold-limit timeout, re-grant, then request drop in cycle 2
      req = 8'h10;
      push(3'd4, 4, 1'b1);
      wait_grant();
      repeat (4) tick();
      push(3'd4, 2, 1'b0);
      wait_grant();
      tick();
      req = 8'h00;
      tick();
      tick();
      tick();

      // done coinciding with the hold limit suppresses timeout
      req = 8'h10;
      push(3'd4, 4, 1'b0);
      wait_grant();
      grant_with_done(4);
      req = 8'h00;
      tick();
      tick();

      // reset mid-grant: ptr is 5, serve 5 so that 4 is owned next
      req = 8'h30;
      push(3'd5, 1, 1'b0);
      wait_grant();
      grant_with_done(1);
      wait_grant();
      chk("pre_reset_idx", 32'(grant_idx), 32'd4);
      tick();
      #1;
      rst = 1'b1;
      #1;
      chk("async_rst_grant", 32'(grant), 32'd0);
      chk("async_rst_valid", 32'(grant_valid), 32'd0);
      chk("async_rst_idx", 32'(grant_idx), 32'd0);
      chk("async_rst_timeout", 32'(timeout), 32'd0);
      push(3'd4, 1, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("post_rst_latency", 32'(grant_valid), 32'd1);
      chk("post_rst_idx", 32'(grant_idx), 32'd4);
      grant_with_done(1);
      req = 8'h00;
      tick();
      tick();
      tick();
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 15, maximum cycles a grant is held before forced revocation; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  8  request vector; bit i = requester i wants the shared resource.
REQ-005 Port: done  input  1  current owner releases the resource; sampled only in GRANT.
REQ-006 Port: grant  output  8  one-hot grant; all-zero when no owner.
REQ-007 Port: grant_idx  output  3  binary index of current owner; 0 when grant_valid=0.
REQ-008 Port: grant_valid  output  1  high while any grant bit is high.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The block SHALL implement FSM states IDLE, GRANT and GAP, registered, with all outputs registered.
REQ-011 grant SHALL be the 3-to-8 one-hot decode of grant_idx, gated by grant_valid; at most one bit high in every cycle.
REQ-012 The block SHALL keep a 3-bit priority pointer ptr; the search order is ptr, ptr+1, ... ptr+7, mod 8.
REQ-013 IDLE, req=0: remain IDLE; outputs 0.
REQ-014 IDLE, req!=0: the next state SHALL be GRANT, with grant_idx set to the first set req bit in search order; grant is visible the cycle after req is sampled (latency 1).
REQ-015 On entering GRANT, hold_cnt SHALL load 1; it SHALL increment by 1 per GRANT cycle, saturating at MAX_HOLD.
REQ-016 GRANT SHALL exit to GAP on the first edge where done=1, or req[grant_idx]=0, or hold_cnt==MAX_HOLD.
REQ-017 Otherwise GRANT SHALL hold; grant_idx and grant SHALL NOT change while in GRANT, regardless of other req bits.
REQ-018 On GRANT->GAP, ptr SHALL load grant_idx+1 mod 8 (7 wraps to 0).
REQ-019 GAP SHALL last exactly one cycle with grant=0 and grant_valid=0, then go to IDLE unconditionally.
REQ-020 timeout SHALL be 1 during the GAP cycle only if the exit cause was hold_cnt==MAX_HOLD with done=0 and req[grant_idx]=1; done or a dropped request in the same cycle SHALL suppress timeout.
REQ-021 MAX_HOLD=1: every grant SHALL last exactly one cycle; timeout SHALL pulse unless done=1 or the request drops in that cycle.
REQ-022 A requester re-asserting immediately SHALL NOT be re-granted before every other pending requester in search order has been served once.
REQ-023 done asserted outside GRANT SHALL be ignored.

Reset
REQ-024 rst=1 SHALL immediately force: state=IDLE, ptr=0, hold_cnt=0, grant=0, grant_idx=0, grant_valid=0, timeout=0, with no clock edge required.
REQ-025 Reset asserted mid-GRANT SHALL drop the grant asynchronously; after release, the first arbitration SHALL use ptr=0.
REQ-026 The first rising edge after rst deasserts SHALL be treated as a normal IDLE cycle.

Verification
REQ-027 Single request: reset, req=8'h04 held, done pulsed on the 3rd GRANT cycle -> grant=8'h04, grant_idx=2 for 3 cycles; 1 GAP cycle; ptr=3; then re-grant of idx 2 after the IDLE cycle.
REQ-028 Round-robin: req=8'hFF held, done pulsed each GRANT cycle -> grant_idx sequence 0,1,2,...,7,0, each separated by GAP+IDLE.
REQ-029 Wrap: ptr=7 (after serving idx 6), req=8'h81 -> idx 7 granted first, then idx 0.
REQ-030 Timeout: MAX_HOLD=4, req=8'h10 held, done=0 -> 4 GRANT cycles, timeout=1 in the GAP cycle, then idx 4 is re-granted.
REQ-031 Simultaneous: MAX_HOLD=4 with done=1 in the 4th GRANT cycle -> GAP with timeout=0; request drop in cycle 2 -> GAP after 2 cycles, timeout=0.
REQ-032 Reset mid-grant: req=8'h30, rst pulsed while idx 4 is owned -> grant=0 without a clock edge; after release, idx 4 is granted (search from ptr=0).
